// File: rtl/tama_pkg.sv
// Shared codes and constants for the tamagotchi status path.
// Imported by the status sequencer, the needs datapath and the display logic.
package tama_pkg;

    localparam int unsigned LVL_W   = 3;
    localparam int unsigned MAX_LVL = 5;

    typedef enum logic [2:0] {
        FELIZ      = 3'b000,
        ABURRIDO   = 3'b001,
        CANSADO    = 3'b010,
        DESCANSO   = 3'b011,
        HAMBRIENTO = 3'b100,
        ENFERMO    = 3'b101,
        MUERTO     = 3'b110,
        ILEGAL     = 3'b111
    } status_e;

    // Levels above MAX_LVL (6, 7) behave as a full level.
    function automatic logic [LVL_W-1:0] clamp_lvl(input logic [LVL_W-1:0] x);
        return (x > LVL_W'(MAX_LVL)) ? LVL_W'(MAX_LVL) : x;
    endfunction

endpackage

// File: rtl/tama_sched_if.sv
// Datapath <-> status sequencer bundle.
//   master : needs datapath (drives levels, death flag, buttons; consumes sclk/status/chg)
//   slave  : tama_sched
interface tama_sched_if;
    import tama_pkg::*;

    logic             regrst;
    logic             dormir;
    logic [LVL_W-1:0] h;
    logic [LVL_W-1:0] d;
    logic [LVL_W-1:0] e;
    logic             enMue;
    logic             sclk;
    logic [2:0]       status;
    logic             chg;

    modport master (
        output regrst, dormir, h, d, e, enMue,
        input  sclk, status, chg
    );

    modport slave (
        input  regrst, dormir, h, d, e, enMue,
        output sclk, status, chg
    );

endinterface

// File: rtl/tama_sched_tick_gen.sv
// Slow clock prescaler.
//   clk, rst_n : system clock, async active-low reset
//   sclk       : 50 % duty slow clock, high for the upper half of each period
//   tick       : one-cycle strobe; the FSM consumes it on the edge where sclk falls
module tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic sclk,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          sclk_q;
    logic          tick_q;
    logic          wrap;

    assign wrap  = (cnt_q == CW'(TICK_DIV - 1));
    assign cnt_d = wrap ? '0 : cnt_q + CW'(1);

    // tick is delayed one cycle from the wrap so status moves with the sclk fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= (cnt_q >= CW'(TICK_DIV / 2));
            tick_q <= wrap;
        end
    end

    assign sclk = sclk_q;
    assign tick = tick_q;

endmodule

// File: rtl/tama_sched.sv
// Status sequencer: generates sclk and evaluates the 3-bit status for the needs datapath.
//   clk, rst_n : system clock, async active-low reset
//   bus.slave  : regrst, dormir, h/d/e, enMue in; sclk, status, chg out (all registered)
module tama_sched
    import tama_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned LOW_LVL    = 1,
    parameter int unsigned SICK_TICKS = 10,
    parameter int unsigned MIN_DWELL  = 2,
    parameter int unsigned FULL_LVL   = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    tama_sched_if.slave  bus
);

    localparam int unsigned ZW = (SICK_TICKS < 1) ? 1 : $clog2(SICK_TICKS + 1);
    localparam int unsigned DW = (MIN_DWELL  < 1) ? 1 : $clog2(MIN_DWELL + 1);

    logic             tick;
    logic             sclk;

    status_e          state_q, state_d;
    logic [ZW-1:0]    zcnt_q,  zcnt_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic             dreq_q,  dreq_d;
    logic             chg_q,   chg_d;

    logic [LVL_W-1:0] h_c, d_c, e_c;
    logic [ZW-1:0]    zcnt_inc_c;
    logic             dreq_eff_c;
    status_e          cand_c;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .sclk  (sclk),
        .tick  (tick)
    );

    assign h_c = clamp_lvl(bus.h);
    assign d_c = clamp_lvl(bus.d);
    assign e_c = clamp_lvl(bus.e);

    // Zero counter value after this tick's update, saturating at SICK_TICKS.
    always_comb begin
        zcnt_inc_c = '0;
        if (h_c == '0 || d_c == '0 || e_c == '0) begin
            zcnt_inc_c = (zcnt_q >= ZW'(SICK_TICKS)) ? zcnt_q : zcnt_q + ZW'(1);
        end
    end

    // A press landing on the tick cycle itself still counts for that tick.
    assign dreq_eff_c = dreq_q | bus.dormir;

    // Need-driven candidate, hunger first.
    always_comb begin
        cand_c = FELIZ;
        if (h_c <= LVL_W'(LOW_LVL))      cand_c = HAMBRIENTO;
        else if (e_c <= LVL_W'(LOW_LVL)) cand_c = CANSADO;
        else if (d_c <= LVL_W'(LOW_LVL)) cand_c = ABURRIDO;
    end

    // Next-state priority chain, evaluated only on tick cycles.
    always_comb begin
        state_d = state_q;
        zcnt_d  = zcnt_q;
        dwell_d = dwell_q;
        dreq_d  = dreq_q;
        chg_d   = 1'b0;

        if (!tick) begin
            if (bus.dormir) dreq_d = 1'b1;
        end else begin
            dreq_d = 1'b0;
            zcnt_d = zcnt_inc_c;

            if (bus.regrst) begin
                state_d = FELIZ;
                zcnt_d  = '0;
            end else if (state_q == ILEGAL) begin
                state_d = FELIZ;
            end else if (state_q == MUERTO) begin
                state_d = MUERTO;
            end else if (bus.enMue) begin
                state_d = MUERTO;
            end else if (state_q == ENFERMO) begin
                if (h_c > LVL_W'(LOW_LVL) && d_c > LVL_W'(LOW_LVL) && e_c > LVL_W'(LOW_LVL))
                    state_d = FELIZ;
            end else if (zcnt_inc_c >= ZW'(SICK_TICKS)) begin
                state_d = ENFERMO;
                zcnt_d  = '0;
            end else if (state_q == DESCANSO) begin
                if (dreq_eff_c || e_c >= LVL_W'(FULL_LVL)) state_d = FELIZ;
            end else if (dreq_eff_c &&
                         (state_q == FELIZ || state_q == ABURRIDO || state_q == CANSADO)) begin
                state_d = DESCANSO;
            end else if (cand_c == state_q || dwell_q >= DW'(MIN_DWELL)) begin
                state_d = cand_c;
            end

            if (bus.regrst || state_d != state_q)
                dwell_d = '0;
            else if (dwell_q < DW'(MIN_DWELL))
                dwell_d = dwell_q + DW'(1);

            chg_d = (state_d != state_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FELIZ;
            zcnt_q  <= '0;
            dwell_q <= '0;
            dreq_q  <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            zcnt_q  <= zcnt_d;
            dwell_q <= dwell_d;
            dreq_q  <= dreq_d;
            chg_q   <= chg_d;
        end
    end

    assign bus.sclk   = sclk;
    assign bus.status = state_q;
    assign bus.chg    = chg_q;

endmodule

// File: doc/tama_sched.md
# tama_sched

Status sequencer for the tamagotchi needs datapath. It generates the slow needs clock `sclk` from `clk` and evaluates the 3-bit `status` that the datapath consumes. The evaluation uses the datapath's h/d/e levels, its death flag `enMue`, the sleep button and the game reset. `status` always changes half a `sclk` period away from the datapath's `sclk` rising edge, so the datapath samples a stable value.

## Interface
Parameters:
- `TICK_DIV`, 50_000_000: `clk` cycles per `sclk` period. Must be even and ≥4.
- `LOW_LVL`, 1: a level ≤ `LOW_LVL` counts as a need.
- `SICK_TICKS`, 10: consecutive ticks with any level == 0 before the block enters ENFERMO.
- `MIN_DWELL`, 2: minimum ticks spent in a normal state before moving to another normal state.
- `FULL_LVL`, 5: energy level that ends DESCANSO.

Ports (clock and reset first):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `regrst` in 1: registered game reset (level), synchronous to `clk`.
- `dormir` in 1: registered sleep/wake button, one-`clk` pulse per press.
- `h` in 3: hunger level, 0..5.
- `d` in 3: fun level, 0..5.
- `e` in 3: energy level, 0..5.
- `enMue` in 1: death flag from the datapath.
- `sclk` out 1: 50 % duty slow clock to the datapath.
- `status` out 3: current state code.
- `chg` out 1: one-`clk` pulse when `status` changes value.

## Operation
- State codes: FELIZ 000, ABURRIDO 001, CANSADO 010, DESCANSO 011, HAMBRIENTO 100, ENFERMO 101, MUERTO 110.
  - Code 111 is illegal. The next tick forces FELIZ.
- Normal states are FELIZ, ABURRIDO, CANSADO and HAMBRIENTO.
- Sleep request latch `dreq`:
  - Set by a `dormir` pulse.
  - Cleared at the next tick, whether or not the request was consumed.
  - A pulse arriving on the tick cycle itself is consumed by that tick.
- Zero counter `zcnt` (saturating):
  - Each tick, `zcnt` increments if any of h/d/e == 0; otherwise it clears.
  - It clears on every entry to ENFERMO or FELIZ-by-reset.
- Dwell counter `dwell` (saturating at `MIN_DWELL`): clears on every state change and increments each tick otherwise.
- On each tick the next state is chosen by the first matching rule:
  1. `regrst` = 1 → FELIZ. Clear `zcnt`, `dwell` and `dreq`.
  2. State is MUERTO → stay in MUERTO.
  3. `enMue` = 1 → MUERTO.
  4. State is ENFERMO:
     - If h, d and e are all > `LOW_LVL` → FELIZ.
     - Otherwise stay in ENFERMO.
  5. `zcnt` reaches `SICK_TICKS` (including the increment made this tick) → ENFERMO.
  6. State is DESCANSO:
     - If `dreq`, or e ≥ `FULL_LVL` → FELIZ.
     - Otherwise stay in DESCANSO.
  7. `dreq`, and state is FELIZ, ABURRIDO or CANSADO → DESCANSO. This bypasses the dwell rule.
  8. Compute the candidate state:
     - h ≤ `LOW_LVL` → HAMBRIENTO.
     - else e ≤ `LOW_LVL` → CANSADO.
     - else d ≤ `LOW_LVL` → ABURRIDO.
     - else FELIZ.
     - If the candidate differs from the current state and `dwell` < `MIN_DWELL`, stay in the current state.
- Input level values of 6 or 7 are treated as 5.

## Timing
- Prescaler `cnt` runs 0..`TICK_DIV`-1 and wraps.
  - `sclk` is registered as (`cnt` ≥ `TICK_DIV`/2).
  - The first `sclk` rise occurs `TICK_DIV`/2 + 1 cycles after reset release.
- A tick happens on the `clk` edge where `cnt` wraps from `TICK_DIV`-1 to 0. That is the same edge on which `sclk` falls.
  - `status` and `chg` update on that edge, so the status-to-datapath-`sclk`-rise margin is `TICK_DIV`/2 cycles.
- `chg` is high for exactly the one cycle after a tick that changed `status`.
- `regrst` and `enMue` are sampled only on tick edges. `regrst` therefore acts within one `sclk` period.
- Reset values: `cnt` = 0, `sclk` = 0, `status` = FELIZ, `chg` = 0, `zcnt` = 0, `dwell` = 0, `dreq` = 0.
  - Asserting `rst_n` mid-period restarts the period immediately.

## Structure
- Shared package `tama_pkg`:
  - Holds the state code constants (FELIZ..MUERTO) and the level constants (MAX_LVL = 5).
  - The needs datapath and the display logic import the same package.
- Sub-module `tick_gen` (parameter `TICK_DIV`; outputs `sclk` and a one-cycle `tick` strobe).
- The next-state priority logic stays in the top module as a single registered FSM.

## Test plan
Bench parameters: `TICK_DIV`=4, `SICK_TICKS`=3, `MIN_DWELL`=2.
1. Release `rst_n`:
   - `sclk` is 0,0,0,1,1,0… with its first rise at cycle 3.
   - `status` = 000 and `chg` = 0 throughout with h=d=e=5.
2. Hold h=5, d=5, e=1 from reset:
   - Tick 1 holds FELIZ (dwell < 2) and tick 2 holds.
   - Tick 3 → 010 with a one-cycle `chg`.
3. Start in FELIZ with dwell satisfied, pulse `dormir`, hold e=2:
   - The next tick → 011.
   - Set e=5 → the next tick → 000.
   - A second `dormir` pulse while in 011 also → 000.
4. Drive d=0 for 3 ticks → 101 on tick 3.
   - Then set h=d=e=5 → the next tick → 000.
5. Assert `enMue`=1 in ENFERMO → the next tick → 110.
   - It stays 110 with h=d=e=5 and `enMue`=0.
   - `regrst`=1 → the next tick → 000.
6. Assert `rst_n` low mid-period while in 100: `status`, `sclk` and `cnt` clear immediately, and there is no `chg` pulse.
